// File: rtl/gcn_pkg.sv
// Shared GCN datapath types: reduction rows, row indices, drain FSM states.
package gcn_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned NLANES = 16;
  localparam int unsigned IDX_W  = 8;

  typedef logic [NLANES-1:0][LANE_W-1:0] row_t;
  typedef logic [IDX_W-1:0]              idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    row_t data;
    idx_t idx;
  } row_entry_t;

  // Per-lane ReLU: a lane with its sign bit set becomes zero.
  function automatic row_t relu_row(input row_t r);
    row_t o;
    for (int i = 0; i < int'(NLANES); i++) begin
      o[i] = r[i][LANE_W-1] ? '0 : r[i];
    end
    return o;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Small skid FIFO of row entries; head is visible while non-empty.
module row_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reduction_drain.sv
// Drains one reduction buffer bank row by row into a ready/valid stream,
// with optional ReLU and credit-based read issue into a small skid FIFO.
module reduction_drain
  import gcn_pkg::*;
#(
  parameter int unsigned NROWS      = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic relu_en,
  output logic busy,
  output logic done,
  output logic sel,
  output logic ren,
  output idx_t ridx,
  input  row_t rdata,
  output logic out_valid,
  input  logic out_ready,
  output row_t out_data,
  output idx_t out_idx
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned ACC_W = IDX_W + 1;
  localparam int unsigned ENT_W = $bits(row_entry_t);

  drain_state_t     state_q, state_d;
  idx_t             issue_q, issue_d;
  idx_t             pend_idx_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sel_d;
  logic             relu_q, relu_d;
  logic             inflight_q;
  logic             busy_d, done_d;
  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ_c;
  logic             credit_ok;
  logic             last_issue;
  row_entry_t       push_entry, head_entry;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_entry.data;
  assign out_idx   = head_entry.idx;
  assign ridx      = issue_q;

  // Occupancy after this cycle's pop plus the read still returning data.
  assign occ_c      = OCC_W'(fifo_count) - OCC_W'(pop) + OCC_W'(inflight_q);
  assign credit_ok  = (32'(occ_c) < FIFO_DEPTH) && !(fifo_full && !pop);
  assign last_issue = (issue_q == IDX_W'(NROWS - 1));

  always_comb begin
    push_entry.data = relu_q ? relu_row(rdata) : rdata;
    push_entry.idx  = pend_idx_q;
  end

  row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_row_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state and read-issue logic.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    acc_d   = acc_q + ACC_W'(pop);
    sel_d   = sel;
    relu_d  = relu_q;
    ren     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRAIN;
          sel_d   = ~sel;
          relu_d  = relu_en;
          issue_d = '0;
          acc_d   = '0;
        end
      end
      DRAIN: begin
        if (credit_ok) begin
          ren     = 1'b1;
          issue_d = last_issue ? '0 : issue_q + IDX_W'(1);
          if (last_issue) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!inflight_q && fifo_empty && (acc_q == ACC_W'(NROWS))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      pend_idx_q <= '0;
      acc_q      <= '0;
      sel        <= 1'b0;
      relu_q     <= 1'b0;
      inflight_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      acc_q      <= acc_d;
      sel        <= sel_d;
      relu_q     <= relu_d;
      inflight_q <= ren;
      busy       <= busy_d;
      done       <= done_d;
      if (ren) begin
        pend_idx_q <= issue_q;
      end
    end
  end

endmodule
